// File: rtl/fft_ram_seq.sv
// FFT sample-RAM sequencer: natural-order load, NUMSTAGES in-place radix-2 DIF
// passes (butterfly read pairs, twiddle indices, delayed write-back), then unload.
// Optional build macro FFT_BITREV_UNLOAD_EN: unload through bit-reversed addresses
// so results leave in natural frequency order; otherwise they leave bit-reversed.
module fft_ram_seq #(
  parameter int NUMSTAGES  = 5,
  parameter int NUMSAMPLES = 32,
  parameter int BFLY_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUMSTAGES-1:0] rd_addr,
  output logic [NUMSTAGES-1:0] wr_addr,
  output logic                 rd_en,
  output logic                 wr_en,
  output logic                 cs,
  output logic                 wr_sel,
  output logic [NUMSTAGES-1:0] stage,
  output logic [NUMSTAGES-2:0] tw_idx,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int TW_W = NUMSTAGES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_UNLOAD, S_FINISH
  } state_t;

  state_t                 state, state_d;
  logic [NUMSTAGES-1:0]   cnt, cnt_d;
  logic [NUMSTAGES-1:0]   stage_d;
  logic [TW_W-1:0]        tw_d;
  logic [NUMSTAGES-1:0]   rd_addr_d, wr_addr_d;
  logic                   rd_en_d, wr_en_d, wr_sel_d;
  logic                   load_we, bfly_rd;
  logic                   wb_en_p   [BFLY_LAT];
  logic [NUMSTAGES-1:0]   wb_addr_p [BFLY_LAT];

  // Low-bit mask covering the butterfly half-span of a stage.
  function automatic logic [NUMSTAGES-1:0] span_mask(input logic [NUMSTAGES-1:0] stg);
    return (NUMSTAGES'(1) << (NUMSTAGES - 1 - int'(stg))) - NUMSTAGES'(1);
  endfunction

  // Insert k[0] into p = k>>1 at bit NUMSTAGES-1-stg (top/bottom of a butterfly).
  function automatic logic [NUMSTAGES-1:0] bfly_addr(input logic [NUMSTAGES-1:0] k,
                                                     input logic [NUMSTAGES-1:0] stg);
    logic [NUMSTAGES-1:0] p, m, lo, hi, bit_b;
    p     = k >> 1;
    m     = span_mask(stg);
    lo    = p & m;
    hi    = p & ~m;
    bit_b = k[0] ? (m + NUMSTAGES'(1)) : '0;
    return (hi << 1) | bit_b | lo;
  endfunction

  // Twiddle index for the pair: (p mod span) scaled by 2**stg.
  function automatic logic [TW_W-1:0] twiddle(input logic [NUMSTAGES-1:0] k,
                                              input logic [NUMSTAGES-1:0] stg);
    logic [NUMSTAGES-1:0] t;
    t = ((k >> 1) & span_mask(stg)) << stg;
    return t[TW_W-1:0];
  endfunction

  // Unload read address for result number u.
  function automatic logic [NUMSTAGES-1:0] unload_addr(input logic [NUMSTAGES-1:0] u);
    logic [NUMSTAGES-1:0] r;
`ifdef FFT_BITREV_UNLOAD_EN
    for (int i = 0; i < NUMSTAGES; i++) r[i] = u[NUMSTAGES-1-i];
`else
    r = u;
`endif
    return r;
  endfunction

  // Next state, counters and next values of every registered output.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    stage_d   = stage;
    tw_d      = tw_idx;
    rd_addr_d = rd_addr;
    rd_en_d   = 1'b0;
    load_we   = 1'b0;
    bfly_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        stage_d = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        stage_d = '0;
        if (in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt + NUMSTAGES'(1);
          if (cnt == NUMSTAGES'(NUMSAMPLES - 1)) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        rd_en_d   = 1'b1;
        bfly_rd   = 1'b1;
        rd_addr_d = bfly_addr(cnt, stage);
        if (!cnt[0]) tw_d = twiddle(cnt, stage);
        cnt_d = cnt + NUMSTAGES'(1);
        if (cnt == NUMSTAGES'(NUMSAMPLES - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt + NUMSTAGES'(1);
        if (cnt == NUMSTAGES'(BFLY_LAT - 1)) begin
          if (stage == NUMSTAGES'(NUMSTAGES - 1)) begin
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage + NUMSTAGES'(1);
            state_d = S_COMPUTE;
          end
        end
      end
      S_UNLOAD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = unload_addr(cnt);
        cnt_d     = cnt + NUMSTAGES'(1);
        if (cnt == NUMSTAGES'(NUMSAMPLES - 1)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state) cnt_d = '0;
    // Load writes and butterfly write-backs never overlap in time.
    wr_en_d   = load_we | wb_en_p[BFLY_LAT-1];
    wr_addr_d = load_we ? cnt : (wb_en_p[BFLY_LAT-1] ? wb_addr_p[BFLY_LAT-1] : wr_addr);
    wr_sel_d  = (state == S_COMPUTE) || (state == S_DRAIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stage     <= '0;
      tw_idx    <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      in_ready  <= 1'b0;
      cs        <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      stage     <= stage_d;
      tw_idx    <= tw_d;
      rd_addr   <= rd_addr_d;
      wr_addr   <= wr_addr_d;
      rd_en     <= rd_en_d;
      wr_en     <= wr_en_d;
      wr_sel    <= wr_sel_d;
      in_ready  <= (state_d == S_LOAD);
      cs        <= (state != S_IDLE) || (state_d != S_IDLE);
      busy      <= (state != S_IDLE) || (state_d != S_IDLE);
      out_valid <= rd_en && ((state == S_UNLOAD) || (state == S_FINISH));
      done      <= (state == S_FINISH);
    end
  end

  // Write-back delay line: butterfly reads replayed BFLY_LAT cycles later as writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        wb_en_p[i]   <= 1'b0;
        wb_addr_p[i] <= '0;
      end
    end else begin
      wb_en_p[0]   <= bfly_rd;
      wb_addr_p[0] <= rd_addr_d;
      for (int i = 1; i < BFLY_LAT; i++) begin
        wb_en_p[i]   <= wb_en_p[i-1];
        wb_addr_p[i] <= wb_addr_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_ram_seq.sv
// Scoreboard bench for fft_ram_seq: expected load writes, butterfly reads/writes and
// unload reads are queued at transform start and consumed as the DUT issues them.
module tb_fft_ram_seq;

  localparam int NS  = 5;
  localparam int N   = 32;
  localparam int LAT = 2;
  localparam int STAGE_CYC = N + LAT;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic          in_ready, rd_en, wr_en, cs, wr_sel, out_valid, busy, done;
  logic [NS-1:0] rd_addr, wr_addr, stage;
  logic [NS-2:0] tw_idx;

  fft_ram_seq #(.NUMSTAGES(NS), .NUMSAMPLES(N), .BFLY_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .rd_en(rd_en), .wr_en(wr_en), .cs(cs),
    .wr_sel(wr_sel), .stage(stage), .tw_idx(tw_idx), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int tw; int stg; bit comp; } rd_t;
  typedef struct { int cyc; int addr; } wr_t;

  rd_t rdq[$];
  wr_t wrq[$];
  int  ldq[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  base     = 0;
  int  done_exp = -1;
  bit  mon_en   = 1'b0;
  bit  prev_unl = 1'b0;
  bit  unl_now;
  rd_t m_e;
  wr_t m_w;
  int  m_ld;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: consume expectations as the DUT drives the RAM pins.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      unl_now = 1'b0;
      chk("out_valid", out_valid, prev_unl);
      if (rd_en) begin
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          m_e = rdq.pop_front();
          chk("rd_addr", rd_addr, m_e.addr);
          chk("rd_cycle", cyc, base + m_e.cyc);
          if (m_e.comp) begin
            chk("tw_idx", tw_idx, m_e.tw);
            chk("stage", stage, m_e.stg);
            m_w.cyc  = base + m_e.cyc + LAT;
            m_w.addr = m_e.addr;
            wrq.push_back(m_w);
          end else begin
            unl_now = 1'b1;
            if (rdq.size() == 0) done_exp = cyc + 1;
          end
        end
      end
      if (wr_en) begin
        if (!wr_sel) begin
          if (ldq.size() == 0) chk("ld_wr_extra", 1, 0);
          else begin
            m_ld = ldq.pop_front();
            chk("ld_wr_addr", wr_addr, m_ld);
            if (ldq.size() == 0) base = cyc + 1;
          end
        end else begin
          if (wrq.size() == 0) chk("bf_wr_extra", 1, 0);
          else begin
            m_w = wrq.pop_front();
            chk("bf_wr_addr", wr_addr, m_w.addr);
            chk("bf_wr_cycle", cyc, m_w.cyc);
          end
        end
      end
      chk("in_ready", in_ready, ldq.size() > 0);
      chk("done", done, cyc == done_exp);
      prev_unl = unl_now;
    end else begin
      prev_unl = 1'b0;
    end
  end

  // Expected sequences for one whole transform, derived from group/span enumeration.
  task automatic push_expect();
    rd_t e;
    int span, p, g, j, top, r;
    for (int i = 0; i < N; i++) ldq.push_back(i);
    for (int s = 0; s < NS; s++) begin
      span = (N / 2) >> s;
      for (int k = 0; k < N; k++) begin
        p = k / 2;
        g = p / span;
        j = p % span;
        top = g * 2 * span + j;
        e.addr = (k % 2) ? top + span : top;
        e.tw   = j << s;
        e.stg  = s;
        e.cyc  = s * STAGE_CYC + k;
        e.comp = 1'b1;
        rdq.push_back(e);
      end
    end
    for (int u = 0; u < N; u++) begin
      r = 0;
      for (int b = 0; b < NS; b++) r = (r << 1) | ((u >> b) & 1);
`ifdef FFT_BITREV_UNLOAD_EN
      e.addr = r;
`else
      e.addr = u;
`endif
      e.tw = 0; e.stg = 0; e.comp = 1'b0;
      e.cyc = NS * STAGE_CYC + u;
      rdq.push_back(e);
    end
  endtask

  task automatic start_and_load(input bit gapped);
    int sent, j;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cs_after_start", cs, 1);
    push_expect();
    sent = 0; j = 0;
    while (sent < N) begin
      in_valid = !(gapped && (j % 3 == 2));
      if (in_valid) sent++;
      j++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      start = poke_start && (c == 50);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    else begin
      chk("busy_at_done", busy, 1);
      @(negedge clk);
      chk("busy_fall", busy, 0);
      chk("cs_fall", cs, 0);
      @(negedge clk);
      chk("rdq_left", rdq.size(), 0);
      chk("wrq_left", wrq.size(), 0);
      chk("ldq_left", ldq.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    // Reset held 3 cycles with a start pulse inside it.
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cs", cs, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_stage", stage, 0);
    chk("rst_tw_idx", tw_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_cs", cs, 0);
    mon_en = 1'b1;

    // Gapped load, full transform, stray start during compute.
    start_and_load(1'b1);
    wait_done(1'b1);

    // Abort in stage 2 mid read phase.
    start_and_load(1'b0);
    for (int c = 0; c < 300 && stage != 2; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("abort_stage", stage, 2);
    chk("abort_rd_en", rd_en, 1);
    rst = 1'b1; mon_en = 1'b0;
    rdq.delete(); wrq.delete(); ldq.delete();
    done_exp = -1;
    @(negedge clk);
    chk("abort_rd_en0", rd_en, 0);
    chk("abort_wr_en0", wr_en, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_in_ready0", in_ready, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_wr_en_idle", wr_en, 0);
    chk("abort_idle_busy", busy, 0);
    mon_en = 1'b1;

    // Clean transform after the abort.
    start_and_load(1'b0);
    wait_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
